// File: rtl/bsg_fsb_pkg.sv
// FSB ring definitions: packet struct macro, switch opcodes and the MURN sequencer state enum.
// BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN adds the DIS state.
`ifndef BSG_FSB_PKT_S_DECLARED
`define BSG_FSB_PKT_S_DECLARED
`define DECLARE_BSG_FSB_PKT_S(width, id_width) \
  typedef struct packed { \
    logic [id_width-1:0]         destid; \
    logic                        cmd; \
    logic [7:0]                  opcode; \
    logic [width-id_width-10:0]  data; \
  } bsg_fsb_pkt_s
`endif

package bsg_fsb_pkg;
  localparam logic [7:0] RNENABLE_CMD        = 8'h01;
  localparam logic [7:0] RNDISABLE_CMD       = 8'h02;
  localparam logic [7:0] RNRESET_ENABLE_CMD  = 8'h03;
  localparam logic [7:0] RNRESET_DISABLE_CMD = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_ON, S_EN, S_WAIT, S_RST_OFF, S_DONE
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
    , S_DIS
`endif
  } bsg_fsb_murn_seq_state_e;
endpackage

// File: rtl/bsg_fsb_murn_cmd_pkt_gen.sv
// Builds a switch command packet (cmd=1) for node base_id_p+idx with the given opcode.
module bsg_fsb_murn_cmd_pkt_gen
  import bsg_fsb_pkg::*;
#(
  parameter int width_p     = 80,
  parameter int id_width_p  = 4,
  parameter int base_id_p   = 0,
  parameter int idx_width_p = 2
) (
  input  logic [idx_width_p-1:0] idx,
  input  logic [7:0]             opcode,
  output logic [width_p-1:0]     pkt
);
  `DECLARE_BSG_FSB_PKT_S(width_p, id_width_p);

  bsg_fsb_pkt_s p;

  always_comb begin
    p        = '0;
    p.destid = id_width_p'(base_id_p) + id_width_p'(idx);
    p.cmd    = 1'b1;
    p.opcode = opcode;
  end

  assign pkt = p;
endmodule

// File: rtl/bsg_fsb_murn_node_sequencer.sv
// Ring injection master: forwards client packets, or on start sends reset-enable,
// enable, hold, reset-disable switch commands to every node.
// BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN adds disable_i and a disable burst from DONE.
module bsg_fsb_murn_node_sequencer
  import bsg_fsb_pkg::*;
#(
  parameter int width_p       = 80,
  parameter int id_width_p    = 4,
  parameter int base_id_p     = 0,
  parameter int num_nodes_p   = 4,
  parameter int hold_cycles_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
  input  logic               disable_i,
`endif
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               done_o
);
  localparam int IDX_W = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;
  localparam int CNT_W = $clog2(hold_cycles_p + 1);

  if (base_id_p + num_nodes_p - 1 >= (1 << id_width_p)) begin : g_bad_ids
    $error("node id range exceeds destid width");
  end
  if (hold_cycles_p < 1) begin : g_bad_hold
    $error("hold_cycles_p must be at least 1");
  end

  bsg_fsb_murn_seq_state_e state_r, state_n, cmd_next;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [7:0]       opcode;
  logic             is_cmd, guard, last;
  logic [width_p-1:0] cmd_pkt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      cnt_r   <= cnt_n;
    end
  end

  // Leaving passthrough only when no client packet is stalled keeps v_o from dropping.
  assign guard = ~(v_i & ~ready_i);
  assign last  = (idx_r == IDX_W'(num_nodes_p - 1));

  always_comb begin
    state_n  = state_r;
    idx_n    = idx_r;
    cnt_n    = cnt_r;
    cmd_next = state_r;
    opcode   = RNRESET_ENABLE_CMD;
    is_cmd   = 1'b0;
    case (state_r)
      S_IDLE:    if (start_i & guard) state_n = S_RST_ON;
      S_RST_ON:  begin is_cmd = 1'b1; opcode = RNRESET_ENABLE_CMD;  cmd_next = S_EN;      end
      S_EN:      begin is_cmd = 1'b1; opcode = RNENABLE_CMD;        cmd_next = S_WAIT;    end
      S_RST_OFF: begin is_cmd = 1'b1; opcode = RNRESET_DISABLE_CMD; cmd_next = S_DONE;    end
      S_WAIT: begin
        if (cnt_r != '0) cnt_n = cnt_r - CNT_W'(1);
        // Leave after the final decrement so WAIT spans hold_cycles_p cycles when unstalled.
        if ((cnt_r <= CNT_W'(1)) & guard) state_n = S_RST_OFF;
      end
      S_DONE: begin
        if (start_i & guard) state_n = S_RST_ON;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
        else if (disable_i & guard) state_n = S_DIS;
`endif
      end
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
      S_DIS:     begin is_cmd = 1'b1; opcode = RNDISABLE_CMD;       cmd_next = S_IDLE;    end
`endif
      default:   state_n = S_IDLE;
    endcase

    if (is_cmd & ready_i) begin
      if (last) begin
        idx_n   = '0;
        state_n = cmd_next;
        if (state_r == S_EN) cnt_n = CNT_W'(hold_cycles_p);
      end else begin
        idx_n = idx_r + IDX_W'(1);
      end
    end
  end

  bsg_fsb_murn_cmd_pkt_gen #(
    .width_p(width_p), .id_width_p(id_width_p),
    .base_id_p(base_id_p), .idx_width_p(IDX_W)
  ) pkt_gen (
    .idx(idx_r), .opcode(opcode), .pkt(cmd_pkt)
  );

  // Gating with reset_n_i makes reset assertion silence the ring immediately.
  assign v_o     = reset_n_i & (is_cmd | v_i);
  assign ready_o = reset_n_i & ~is_cmd & ready_i & v_i;
  assign data_o  = is_cmd ? cmd_pkt : data_i;
  assign busy_o  = (state_r == S_RST_ON) | (state_r == S_EN) | (state_r == S_WAIT)
                 | (state_r == S_RST_OFF)
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
                 | (state_r == S_DIS)
`endif
                 ;
  assign done_o  = (state_r == S_DONE);
endmodule

// File: tb/tb_bsg_fsb_murn_node_sequencer.sv
// Randomized bench for the MURN node sequencer against a queue-based expectation model.
module tb_bsg_fsb_murn_node_sequencer;
  localparam int W = 80;
  localparam logic [7:0] OP_EN = 8'h01, OP_DIS = 8'h02, OP_RE = 8'h03, OP_RD = 8'h04;

  logic clk_i = 1'b0, reset_n_i, start_i, v_i, ready_i;
  logic [W-1:0] data_i, data_o;
  logic ready_o, v_o, busy_o, done_o;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
  logic disable_i;
`endif
  int total = 0, bad = 0;

  bsg_fsb_murn_node_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
    .disable_i(disable_i),
`endif
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
    .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Command packet: destid in the top 4 bits, cmd bit, 8-bit opcode, zero payload.
  function automatic logic [W-1:0] exp_pkt(input int id, input logic [7:0] op);
    logic [W-1:0] p;
    p = '0;
    p[79:76] = id[3:0];
    p[75] = 1'b1;
    p[74:67] = op;
    return p;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; start_i = 0; v_i = 0; ready_i = 0; data_i = '0;
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
    disable_i = 0;
`endif
    repeat (2) tick();
    reset_n_i = 1'b1;
  endtask

  task automatic start_seq();
    start_i = 1; v_i = 0; ready_i = 1;
    tick();
    start_i = 0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; start_i = 1; v_i = 1; ready_i = 1; data_i = rnd_data();
    #3;
    total++;
    if ({v_o, ready_o, busy_o, done_o} !== 4'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=0000", {v_o, ready_o, busy_o, done_o});
    end
    do_reset();
  endtask

  task automatic test_sequence();
    logic         q_cmd[$];
    logic [W-1:0] q_pkt[$];
    logic [7:0]   ops[3];
    ops = '{OP_RE, OP_EN, OP_RD};
    for (int p = 0; p < 3; p++) begin
      if (p == 2) for (int k = 0; k < 16; k++) begin q_cmd.push_back(0); q_pkt.push_back('0); end
      for (int n = 0; n < 4; n++) begin q_cmd.push_back(1); q_pkt.push_back(exp_pkt(n, ops[p])); end
    end
    start_seq();
    for (int c = 0; c < q_cmd.size(); c++) begin
      v_i = 1'($urandom); data_i = rnd_data(); ready_i = 1;
      @(negedge clk_i);
      total++;
      if (q_cmd[c]) begin
        if (!(v_o === 1 && data_o === q_pkt[c] && ready_o === 0 && busy_o === 1)) begin
          bad++; $display("FAIL seq_cmd cyc=%0d got v=%b d=%h r=%b b=%b exp v=1 d=%h r=0 b=1",
                          c, v_o, data_o, ready_o, busy_o, q_pkt[c]);
        end
      end else if (!(v_o === v_i && data_o === data_i && ready_o === v_i && busy_o === 1)) begin
        bad++; $display("FAIL seq_wait cyc=%0d got v=%b r=%b b=%b exp v=%b r=%b b=1",
                        c, v_o, ready_o, busy_o, v_i, v_i);
      end
      tick();
    end
    v_i = 0;
    @(negedge clk_i);
    total++;
    if (!(done_o === 1 && busy_o === 0)) begin
      bad++; $display("FAIL seq_done got done=%b busy=%b exp done=1 busy=0", done_o, busy_o);
    end
  endtask

  // Random back-pressure through RST_ON/EN, then passthrough checks in WAIT and DONE.
  task automatic test_stall_passthrough();
    logic [W-1:0] q[$];
    logic pat[4];
    int k, cyc;
    pat = '{1, 0, 0, 1};
    do_reset();
    for (int n = 0; n < 4; n++) q.push_back(exp_pkt(n, OP_RE));
    for (int n = 0; n < 4; n++) q.push_back(exp_pkt(n, OP_EN));
    start_seq();
    k = 0;
    while (q.size() > 0 && k < 100) begin
      v_i = 1'($urandom); data_i = rnd_data();
      ready_i = (k < 4) ? 1'b1 : (k < 8) ? pat[k-4] : 1'($urandom);
      @(negedge clk_i);
      total++;
      if (!(v_o === 1 && data_o === q[0] && ready_o === 0)) begin
        bad++; $display("FAIL stall_pkt k=%0d got v=%b d=%h r=%b exp v=1 d=%h r=0",
                        k, v_o, data_o, ready_o, q[0]);
      end
      if (ready_i) void'(q.pop_front());
      tick();
      k++;
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL stall_timeout left=%0d exp=0", q.size()); end
    for (int c = 0; c < 5; c++) begin
      v_i = 1; data_i = W'('hA5); ready_i = 1'($urandom);
      @(negedge clk_i);
      total++;
      if (!(v_o === 1 && data_o === W'('hA5) && ready_o === ready_i && busy_o === 1)) begin
        bad++; $display("FAIL wait_pass got v=%b d=%h r=%b b=%b exp v=1 d=a5 r=%b b=1",
                        v_o, data_o, ready_o, busy_o, ready_i);
      end
      tick();
    end
    v_i = 0; ready_i = 1; cyc = 0;
    while (!done_o && cyc < 100) begin tick(); cyc++; end
    total++;
    if (done_o !== 1) begin bad++; $display("FAIL done_timeout got=%b exp=1", done_o); end
    for (int c = 0; c < 5; c++) begin
      v_i = 1; data_i = W'('hA5); ready_i = 1'($urandom);
      @(negedge clk_i);
      total++;
      if (!(v_o === 1 && data_o === W'('hA5) && ready_o === ready_i && done_o === 1)) begin
        bad++; $display("FAIL done_pass got v=%b d=%h r=%b dn=%b exp v=1 d=a5 r=%b dn=1",
                        v_o, data_o, ready_o, done_o, ready_i);
      end
      tick();
    end
    v_i = 0;
  endtask

  task automatic test_start_stall();
    do_reset();
    v_i = 1; ready_i = 0; start_i = 1;
    for (int c = 0; c < 5; c++) begin
      data_i = rnd_data();
      @(negedge clk_i);
      total++;
      if (!(v_o === 1 && data_o === data_i && busy_o === 0 && ready_o === 0)) begin
        bad++; $display("FAIL start_stall c=%0d got v=%b b=%b r=%b exp v=1 b=0 r=0",
                        c, v_o, busy_o, ready_o);
      end
      tick();
    end
    ready_i = 1;
    @(negedge clk_i);
    total++;
    if (!(ready_o === 1 && busy_o === 0)) begin
      bad++; $display("FAIL start_accept got r=%b b=%b exp r=1 b=0", ready_o, busy_o);
    end
    tick();
    v_i = 0; start_i = 0;
    @(negedge clk_i);
    total++;
    if (!(busy_o === 1 && v_o === 1 && data_o === exp_pkt(0, OP_RE))) begin
      bad++; $display("FAIL start_enter got b=%b v=%b d=%h exp b=1 v=1 d=%h",
                      busy_o, v_o, data_o, exp_pkt(0, OP_RE));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_seq();
    repeat (2) tick();
    v_i = 1; data_i = rnd_data();
    #2 reset_n_i = 0;
    #1;
    total++;
    if (!(v_o === 0 && busy_o === 0 && ready_o === 0)) begin
      bad++; $display("FAIL midreset got v=%b b=%b r=%b exp 0 0 0", v_o, busy_o, ready_o);
    end
    @(negedge clk_i); reset_n_i = 1; v_i = 0;
    tick();
    total++;
    if (!(busy_o === 0 && done_o === 0 && v_o === 0)) begin
      bad++; $display("FAIL post_reset got b=%b dn=%b v=%b exp 0 0 0", busy_o, done_o, v_o);
    end
    start_seq();
    @(negedge clk_i);
    total++;
    if (data_o !== exp_pkt(0, OP_RE)) begin
      bad++; $display("FAIL restart_pkt got=%h exp=%h", data_o, exp_pkt(0, OP_RE));
    end
  endtask

`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
  task automatic test_disable();
    disable_i = 1; v_i = 0; ready_i = 1;
    tick();
    disable_i = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      total++;
      if (!(v_o === 1 && data_o === exp_pkt(n, OP_DIS))) begin
        bad++; $display("FAIL dis_pkt n=%0d got v=%b d=%h exp=%h", n, v_o, data_o, exp_pkt(n, OP_DIS));
      end
      tick();
    end
    @(negedge clk_i);
    total++;
    if (!(done_o === 0 && busy_o === 0)) begin
      bad++; $display("FAIL dis_idle got dn=%b b=%b exp 0 0", done_o, busy_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
`ifdef BSG_FSB_MURN_NODE_SEQUENCER_DISABLE_EN
    tick();
    test_disable();
`endif
    test_stall_passthrough();
    test_start_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
